// File: rtl/adc_conditioner.sv
// adc_conditioner: registers raw ADC samples, removes a block-averaged DC offset,
// flags sustained over-range (sticky) and hands samples on through a 2-entry buffer.
// Latency: two clk_adc edges pin-to-output; a push into a full buffer with no pop is dropped and counted.
// Optional build macro ADC_COND_TEST_PATTERN_EN adds tp_en, which substitutes an internal ramp for the pins.
module adc_conditioner #(
  parameter int ADC_W      = 10,
  parameter int OUT_W      = 32,
  parameter int AVG_LOG2   = 16,
  parameter int OVR_THRESH = 3,
  parameter int DROP_W     = 16
) (
  input  logic              clk_adc,
  input  logic              rst_n,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic              adc_valid,
  input  logic              adc_ovr,
  input  logic              dc_enable,
  input  logic              ovr_clear,
`ifdef ADC_COND_TEST_PATTERN_EN
  input  logic              tp_en,
`endif
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow_detect,
  output logic              dc_locked,
  output logic [DROP_W-1:0] drop_count
);

  localparam int ACC_W = ADC_W + AVG_LOG2;

  // Source selection ahead of the input register
  logic [ADC_W-1:0] in_data;
  logic             in_valid;
  logic             in_ovr;

`ifdef ADC_COND_TEST_PATTERN_EN
  logic [ADC_W-1:0] ramp;

  // Free-running ramp; natural wrap at 2^ADC_W-1 back to 0
  always_ff @(posedge clk_adc or negedge rst_n) begin
    if (!rst_n) ramp <= '0;
    else        ramp <= ramp + 1'b1;
  end

  // Ramp replaces the pins, always valid and never over-range
  always_comb begin
    in_data  = tp_en ? ramp : adc_data;
    in_valid = tp_en ? 1'b1 : adc_valid;
    in_ovr   = tp_en ? 1'b0 : adc_ovr;
  end
`else
  // Pins feed the input register directly
  always_comb begin
    in_data  = adc_data;
    in_valid = adc_valid;
    in_ovr   = adc_ovr;
  end
`endif

  // Stage S1: single register on the ADC interface
  logic signed [ADC_W-1:0] s1_data;
  logic                    s1_valid;
  logic                    s1_ovr;

  // Capture the selected ADC inputs
  always_ff @(posedge clk_adc or negedge rst_n) begin
    if (!rst_n) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      s1_ovr   <= 1'b0;
    end else begin
      s1_data  <= in_data;
      s1_valid <= in_valid;
      s1_ovr   <= in_ovr;
    end
  end

  // DC estimator: block sum of 2^AVG_LOG2 samples, floor-divided by shifting
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  acc_mean;
  logic [AVG_LOG2-1:0]      smp_cnt;
  logic signed [ADC_W-1:0]  offset;
  logic                     blk_end;

  assign acc_sum  = acc + {{AVG_LOG2{s1_data[ADC_W-1]}}, s1_data};
  assign acc_mean = acc_sum >>> AVG_LOG2;
  assign blk_end  = (smp_cnt == '1);

  // Accumulate valid samples; publish the mean and restart on the last sample of a block
  always_ff @(posedge clk_adc or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      smp_cnt   <= '0;
      offset    <= '0;
      dc_locked <= 1'b0;
    end else if (s1_valid) begin
      smp_cnt <= smp_cnt + 1'b1;
      if (blk_end) begin
        offset    <= acc_mean[ADC_W-1:0];
        acc       <= '0;
        dc_locked <= 1'b1;
      end else begin
        acc <= acc_sum;
      end
    end
  end

  // Correction: one extra bit of headroom over ADC_W means the difference never overflows
  logic signed [OUT_W-1:0] sample_ext;
  logic signed [OUT_W-1:0] offset_ext;
  logic signed [OUT_W-1:0] corr;

  assign sample_ext = {{(OUT_W-ADC_W){s1_data[ADC_W-1]}}, s1_data};
  assign offset_ext = {{(OUT_W-ADC_W){offset[ADC_W-1]}}, offset};

  // Subtract the estimate only once one exists and correction is requested
  always_comb begin
    corr = sample_ext;
    if (dc_enable && dc_locked) corr = sample_ext - offset_ext;
  end

  // Overflow run-length detector
  logic [3:0] ovr_cnt;
  logic [4:0] ovr_next;
  logic       ovr_hit;

  assign ovr_next = {1'b0, ovr_cnt} + 5'd1;
  assign ovr_hit  = s1_ovr && (ovr_next == 5'(OVR_THRESH));

  // Count consecutive over-range cycles (saturating); the flag is sticky and a set beats a clear
  always_ff @(posedge clk_adc or negedge rst_n) begin
    if (!rst_n) begin
      ovr_cnt         <= '0;
      overflow_detect <= 1'b0;
    end else begin
      if (!s1_ovr)                ovr_cnt <= '0;
      else if (ovr_cnt != 4'hF)   ovr_cnt <= ovr_cnt + 1'b1;
      if (ovr_hit)                overflow_detect <= 1'b1;
      else if (ovr_clear)         overflow_detect <= 1'b0;
    end
  end

  // 2-entry output buffer
  logic [OUT_W-1:0] buf0;
  logic [OUT_W-1:0] buf1;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  assign full      = (count == 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = rd_ptr ? buf1 : buf0;
  assign pop       = out_valid && out_ready;
  assign push      = s1_valid && (!full || pop);
  assign drop      = s1_valid && full && !pop;

  // Buffer storage, pointers and occupancy; a simultaneous pop frees room for the push even when full
  always_ff @(posedge clk_adc or negedge rst_n) begin
    if (!rst_n) begin
      buf0   <= '0;
      buf1   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        if (wr_ptr) buf1 <= corr;
        else        buf0 <= corr;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Saturating count of samples lost to a full buffer
  always_ff @(posedge clk_adc or negedge rst_n) begin
    if (!rst_n)                          drop_count <= '0;
    else if (drop && (drop_count != '1)) drop_count <= drop_count + 1'b1;
  end

endmodule

// File: tb/tb_adc_conditioner.sv
// Testbench for adc_conditioner: directed scenarios plus a random phase,
// all outputs compared every cycle against a behavioural model
// (block means, run lengths, a sample queue).
module tb_adc_conditioner;

  localparam int ADC_W      = 10;
  localparam int OUT_W      = 32;
  localparam int AVG_LOG2   = 4;
  localparam int OVR_THRESH = 3;
  localparam int DROP_W     = 4;
  localparam int BLK        = 1 << AVG_LOG2;
  localparam int DROP_MAX   = (1 << DROP_W) - 1;

  logic              clk_adc = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADC_W-1:0]  adc_data = '0;
  logic              adc_valid = 1'b0;
  logic              adc_ovr = 1'b0;
  logic              dc_enable = 1'b0;
  logic              ovr_clear = 1'b0;
  logic              tp_en = 1'b0;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              overflow_detect;
  logic              dc_locked;
  logic [DROP_W-1:0] drop_count;

  adc_conditioner #(
    .ADC_W(ADC_W), .OUT_W(OUT_W), .AVG_LOG2(AVG_LOG2),
    .OVR_THRESH(OVR_THRESH), .DROP_W(DROP_W)
  ) dut (
    .clk_adc(clk_adc),
    .rst_n(rst_n),
    .adc_data(adc_data),
    .adc_valid(adc_valid),
    .adc_ovr(adc_ovr),
    .dc_enable(dc_enable),
    .ovr_clear(ovr_clear),
`ifdef ADC_COND_TEST_PATTERN_EN
    .tp_en(tp_en),
`endif
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow_detect(overflow_detect),
    .dc_locked(dc_locked),
    .drop_count(drop_count)
  );

  always #5 clk_adc = ~clk_adc;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  int m_s1_data;
  bit m_s1_vld;
  bit m_s1_ovr;
  int m_sum;
  int m_n;
  int m_offset;
  bit m_locked;
  int m_run;
  bit m_flag;
  int m_q[$];
  int m_drop;

  task automatic model_reset();
    m_s1_data = 0; m_s1_vld = 0; m_s1_ovr = 0;
    m_sum = 0; m_n = 0; m_offset = 0; m_locked = 0;
    m_run = 0; m_flag = 0; m_drop = 0;
    m_q.delete();
  endtask

  // Advance the model across one rising edge using the inputs presented to it
  task automatic model_edge(input bit en, input bit clr, input bit rdy);
    int corr;
    if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
    if (m_s1_vld) begin
      corr = (en && m_locked) ? (m_s1_data - m_offset) : m_s1_data;
      if (m_q.size() < 2) m_q.push_back(corr);
      else if (m_drop < DROP_MAX) m_drop++;
      m_sum += m_s1_data;
      m_n++;
      if (m_n == BLK) begin
        m_offset = m_sum >>> AVG_LOG2;
        m_sum = 0;
        m_n = 0;
        m_locked = 1;
      end
    end
    m_run = m_s1_ovr ? m_run + 1 : 0;
    if (m_s1_ovr && m_run == OVR_THRESH) m_flag = 1;
    else if (clr) m_flag = 0;
    m_s1_data = int'($signed(adc_data));
    m_s1_vld  = adc_valid;
    m_s1_ovr  = adc_ovr;
  endtask

  task automatic check_outputs(input string tag);
    logic [OUT_W-1:0]  exp_data;
    logic [DROP_W-1:0] exp_drop;
    bit                exp_vld;
    exp_vld  = (m_q.size() != 0);
    exp_drop = DROP_W'(m_drop);
    checks++;
    assert (out_valid === exp_vld) else begin
      failures++;
      $error("FAIL %s out_valid got=%0b exp=%0b", tag, out_valid, exp_vld);
    end
    if (exp_vld) begin
      exp_data = OUT_W'(m_q[0]);
      checks++;
      assert (out_data === exp_data) else begin
        failures++;
        $error("FAIL %s out_data got=%h exp=%h", tag, out_data, exp_data);
      end
    end
    checks++;
    assert (overflow_detect === m_flag) else begin
      failures++;
      $error("FAIL %s overflow_detect got=%0b exp=%0b", tag, overflow_detect, m_flag);
    end
    checks++;
    assert (dc_locked === m_locked) else begin
      failures++;
      $error("FAIL %s dc_locked got=%0b exp=%0b", tag, dc_locked, m_locked);
    end
    checks++;
    assert (drop_count === exp_drop) else begin
      failures++;
      $error("FAIL %s drop_count got=%0d exp=%0d", tag, drop_count, exp_drop);
    end
  endtask

  task automatic check_zero(input string tag);
    logic [OUT_W+4-1:0] got;
    got = {out_data, out_valid, overflow_detect, dc_locked, |drop_count};
    checks++;
    assert (got === '0) else begin
      failures++;
      $error("FAIL %s outputs-not-zero got=%h exp=0", tag, got);
    end
  endtask

  // Called just after a falling edge: drive inputs, step the model, check after the next edge
  task automatic step(input string tag, input int d, input bit v, input bit o,
                      input bit en, input bit clr, input bit rdy);
    adc_data  = d[ADC_W-1:0];
    adc_valid = v;
    adc_ovr   = o;
    dc_enable = en;
    ovr_clear = clr;
    out_ready = rdy;
    model_edge(en, clr, rdy);
    @(negedge clk_adc);
    check_outputs(tag);
  endtask

  initial begin
    model_reset();
    @(negedge clk_adc);
    @(negedge clk_adc);
    check_zero("reset_state");
    rst_n = 1'b1;

    // Constant 100 with correction on: locks after 16 samples, then reads 0
    for (int i = 0; i < 24; i++) step("const100", 100, 1, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++)  step("const100_tail", 0, 0, 0, 1, 0, 1);

    // Correction off, -1 passes through sign-extended
    step("minus1", 10'h3FF, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("minus1_tail", 0, 0, 0, 0, 0, 1);

    // Over-range: burst of 2 (no set), burst of 3 (set), clear, then clear coincident with set
    step("ovr", 0, 0, 1, 0, 0, 1);
    step("ovr", 0, 0, 1, 0, 0, 1);
    step("ovr", 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("ovr", 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) step("ovr_hold", 0, 0, 0, 0, 0, 1);
    step("ovr_clear", 0, 0, 0, 0, 1, 1);
    step("ovr_cleared", 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("ovr2", 0, 0, 1, 0, 0, 1);
    step("ovr_set_vs_clear", 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 2; i++) step("ovr_after", 0, 0, 0, 0, 0, 1);
    step("ovr_clear2", 0, 0, 0, 0, 1, 1);
    step("ovr_idle", 0, 0, 0, 0, 0, 1);

    // Backpressure: 5 samples into a stalled buffer, two kept, three dropped, then drained in order
    for (int i = 0; i < 5; i++) step("stall", 11 * (i + 1), 1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step("stall_hold", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("drain", 0, 0, 0, 0, 0, 1);
    // Drop counter saturation
    for (int i = 0; i < 22; i++) step("drop_sat", i, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("drop_sat_drain", 0, 0, 0, 0, 0, 1);

    // Full signed ramp with correction: offset tracks the floor of each block mean
    for (int i = -512; i < 512; i++) step("ramp", i, 1, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) step("ramp_tail", 0, 0, 0, 1, 0, 1);

    // Random traffic
    begin
      bit en = 1;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 63) == 0) en = ~en;
        step("random", int'($urandom_range(0, 1023)), $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0, en, $urandom_range(0, 15) == 0,
             $urandom_range(0, 3) != 0);
      end
    end

    // Reset mid-stream with the buffer full
    for (int i = 0; i < 4; i++) step("prefill", 50 + i, 1, 1, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    model_reset();
    adc_valid = 1'b0; adc_ovr = 1'b0; ovr_clear = 1'b0;
    @(negedge clk_adc);
    check_zero("reset_held");
    @(negedge clk_adc);
    rst_n = 1'b1;
    step("post_reset", 77, 1, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) step("post_reset_tail", 0, 0, 0, 1, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
